// File: rtl/iob_acc_ctrl.sv
// iob_acc_ctrl: frame-accumulate controller with a loadable accumulator.
// It takes a start command with a frame length, then consumes exactly that many
// samples over a valid/ready stream. The first sample of a frame loads the
// accumulator and each later sample is added to it. The sum is then presented
// on a valid/ready result port.
// Optional build macro: IOB_ACC_CTRL_SAT_EN. When it is defined, the accumulate
// step saturates to all ones instead of wrapping.
module iob_acc_ctrl #(
    parameter int unsigned DATA_W = 21,
    parameter int unsigned LEN_W  = 8
) (
    input  logic              clk_i,
    input  logic              cke_i,
    input  logic              arst_n_i,
    input  logic              start_i,
    input  logic [LEN_W-1:0]  len_i,
    output logic              busy_o,
    input  logic              s_valid_i,
    input  logic [DATA_W-1:0] s_data_i,
    output logic              s_ready_o,
    output logic              m_valid_o,
    output logic [DATA_W-1:0] m_data_o,
    input  logic              m_ready_i,
    output logic              ovf_o
);

    localparam int unsigned SUM_W = DATA_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FIRST = 2'd1,
        S_ACC   = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t             r_state;
    logic [LEN_W-1:0]   r_count;
    logic [LEN_W-1:0]   r_len;
    logic [DATA_W-1:0]  r_acc;
    logic               r_ovf;
    logic               r_busy;
    logic               r_s_ready;
    logic               r_m_valid;

    state_t             w_state_nxt;
    logic [LEN_W-1:0]   w_count_nxt;
    logic [LEN_W-1:0]   w_len_nxt;
    logic [DATA_W-1:0]  w_acc_nxt;
    logic               w_ovf_nxt;
    logic               w_busy_nxt;
    logic               w_s_ready_nxt;
    logic               w_m_valid_nxt;

    logic               w_s_hs;
    logic               w_m_hs;
    logic [SUM_W-1:0]   w_sum;
    logic               w_carry;
    logic [DATA_W-1:0]  w_sum_lo;
    logic [DATA_W-1:0]  w_acc_add;
    logic [LEN_W-1:0]   w_count_inc;

    // Handshakes use the registered ready/valid that the ports present.
    assign w_s_hs      = s_valid_i & r_s_ready;
    assign w_m_hs      = r_m_valid & m_ready_i;

    // The adder is one bit wider than the data so that the carry-out is visible.
    assign w_sum       = SUM_W'(r_acc) + SUM_W'(s_data_i);
    assign w_carry     = w_sum[DATA_W];
    assign w_sum_lo    = w_sum[DATA_W-1:0];
    assign w_count_inc = r_count + LEN_W'(1);

    // Accumulate result: saturating or modulo, selected at build time.
`ifdef IOB_ACC_CTRL_SAT_EN
    assign w_acc_add = w_carry ? {DATA_W{1'b1}} : w_sum_lo;
`else
    assign w_acc_add = w_sum_lo;
`endif

    // Next-state, datapath and next-output decode.
    always_comb begin
        w_state_nxt   = r_state;
        w_count_nxt   = r_count;
        w_len_nxt     = r_len;
        w_acc_nxt     = r_acc;
        w_ovf_nxt     = r_ovf;
        w_busy_nxt    = 1'b0;
        w_s_ready_nxt = 1'b0;
        w_m_valid_nxt = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    if (len_i != '0) begin
                        w_len_nxt   = len_i;
                        w_count_nxt = '0;
                        w_state_nxt = S_FIRST;
                    end else begin
                        // An empty frame reports a sum of zero.
                        w_acc_nxt   = '0;
                        w_ovf_nxt   = 1'b0;
                        w_state_nxt = S_OUT;
                    end
                end
            end
            S_FIRST: begin
                if (w_s_hs) begin
                    w_acc_nxt   = s_data_i;
                    w_ovf_nxt   = 1'b0;
                    w_count_nxt = LEN_W'(1);
                    w_state_nxt = (r_len == LEN_W'(1)) ? S_OUT : S_ACC;
                end
            end
            S_ACC: begin
                if (w_s_hs) begin
                    w_acc_nxt   = w_acc_add;
                    w_ovf_nxt   = r_ovf | w_carry;
                    w_count_nxt = w_count_inc;
                    if (w_count_inc == r_len) begin
                        w_state_nxt = S_OUT;
                    end
                end
            end
            S_OUT: begin
                if (w_m_hs) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_busy_nxt    = (w_state_nxt != S_IDLE);
        w_s_ready_nxt = (w_state_nxt == S_FIRST) || (w_state_nxt == S_ACC);
        w_m_valid_nxt = (w_state_nxt == S_OUT);
    end

    // State, datapath and output registers. All of them are frozen while cke_i is low.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_len     <= '0;
            r_acc     <= '0;
            r_ovf     <= 1'b0;
            r_busy    <= 1'b0;
            r_s_ready <= 1'b0;
            r_m_valid <= 1'b0;
        end else if (cke_i) begin
            r_state   <= w_state_nxt;
            r_count   <= w_count_nxt;
            r_len     <= w_len_nxt;
            r_acc     <= w_acc_nxt;
            r_ovf     <= w_ovf_nxt;
            r_busy    <= w_busy_nxt;
            r_s_ready <= w_s_ready_nxt;
            r_m_valid <= w_m_valid_nxt;
        end
    end

    // The ports are driven straight from the registers.
    assign busy_o    = r_busy;
    assign s_ready_o = r_s_ready;
    assign m_valid_o = r_m_valid;
    assign m_data_o  = r_acc;
    assign ovf_o     = r_ovf;

endmodule

// File: tb/tb_iob_acc_ctrl.sv
// Directed bench for iob_acc_ctrl. Inputs are driven and outputs are checked
// on the falling clock edge.
module tb_iob_acc_ctrl;

    localparam int unsigned DATA_W = 21;
    localparam int unsigned LEN_W  = 8;

    logic              clk_i = 1'b0;
    logic              cke_i;
    logic              arst_n_i;
    logic              start_i;
    logic [LEN_W-1:0]  len_i;
    logic              busy_o;
    logic              s_valid_i;
    logic [DATA_W-1:0] s_data_i;
    logic              s_ready_o;
    logic              m_valid_o;
    logic [DATA_W-1:0] m_data_o;
    logic              m_ready_i;
    logic              ovf_o;

    int n_cmp = 0;
    int n_err = 0;

    iob_acc_ctrl #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clk_i     (clk_i),
        .cke_i     (cke_i),
        .arst_n_i  (arst_n_i),
        .start_i   (start_i),
        .len_i     (len_i),
        .busy_o    (busy_o),
        .s_valid_i (s_valid_i),
        .s_data_i  (s_data_i),
        .s_ready_o (s_ready_o),
        .m_valid_o (m_valid_o),
        .m_data_o  (m_data_o),
        .m_ready_i (m_ready_i),
        .ovf_o     (ovf_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk_i);
    endtask

    // Offer one sample and wait a bounded time for it to be accepted.
    task automatic feed(input logic [DATA_W-1:0] d);
        bit done;
        done      = 1'b0;
        s_valid_i = 1'b1;
        s_data_i  = d;
        for (int i = 0; i < 16; i++) begin
            if (s_ready_o) begin
                step();
                done = 1'b1;
                break;
            end
            step();
        end
        if (!done) chk("feed_timeout", 32'(s_ready_o), 32'd1);
        s_valid_i = 1'b0;
    endtask

    task automatic start(input logic [LEN_W-1:0] l);
        start_i = 1'b1;
        len_i   = l;
        step();
        start_i = 1'b0;
        len_i   = '0;
    endtask

    initial begin
        cke_i     = 1'b1;
        arst_n_i  = 1'b0;
        start_i   = 1'b0;
        len_i     = '0;
        s_valid_i = 1'b0;
        s_data_i  = '0;
        m_ready_i = 1'b1;

        // Reset values
        step();
        chk("rst_busy",   32'(busy_o),    32'd0);
        chk("rst_sready", 32'(s_ready_o), 32'd0);
        chk("rst_mvalid", 32'(m_valid_o), 32'd0);
        chk("rst_mdata",  32'(m_data_o),  32'd0);
        chk("rst_ovf",    32'(ovf_o),     32'd0);
        arst_n_i = 1'b1;
        step();
        chk("idle_busy", 32'(busy_o), 32'd0);

        // Basic frame of four samples: 1 + 2 + 3 + 4 = 10
        start(8'd4);
        chk("b_sready_after_start", 32'(s_ready_o), 32'd1);
        chk("b_busy", 32'(busy_o), 32'd1);
        feed(21'd1); feed(21'd2); feed(21'd3); feed(21'd4);
        chk("b_mvalid", 32'(m_valid_o), 32'd1);
        chk("b_mdata",  32'(m_data_o),  32'd10);
        chk("b_ovf",    32'(ovf_o),     32'd0);
        chk("b_sready_out", 32'(s_ready_o), 32'd0);
        step();
        chk("b_mvalid_once", 32'(m_valid_o), 32'd0);
        chk("b_busy_idle",   32'(busy_o),    32'd0);

        // Backpressure on both sides: 5 + 7 + 9 = 21
        m_ready_i = 1'b0;
        start(8'd3);
        feed(21'd5);
        step(); step();
        chk("bp_gap_mvalid", 32'(m_valid_o), 32'd0);
        feed(21'd7);
        step();
        feed(21'd9);
        for (int i = 0; i < 4; i++) begin
            chk("bp_hold_mvalid", 32'(m_valid_o), 32'd1);
            chk("bp_hold_mdata",  32'(m_data_o),  32'd21);
            chk("bp_hold_busy",   32'(busy_o),    32'd1);
            step();
        end
        m_ready_i = 1'b1;
        step();
        chk("bp_release_mvalid", 32'(m_valid_o), 32'd0);
        chk("bp_release_busy",   32'(busy_o),    32'd0);

        // Zero-length frame
        start(8'd0);
        chk("z_mvalid", 32'(m_valid_o), 32'd1);
        chk("z_mdata",  32'(m_data_o),  32'd0);
        chk("z_sready", 32'(s_ready_o), 32'd0);
        step();
        chk("z_busy", 32'(busy_o), 32'd0);
        chk("z_sready_idle", 32'(s_ready_o), 32'd0);

        // One-sample frame
        start(8'd1);
        feed(21'h1ABCDE);
        chk("one_mvalid", 32'(m_valid_o), 32'd1);
        chk("one_mdata",  32'(m_data_o),  32'h1ABCDE);
        step();

        // Wrap / saturation and carry-out flag
        start(8'd2);
        feed(21'h1FFFFF);
        feed(21'h000002);
        chk("w_mvalid", 32'(m_valid_o), 32'd1);
`ifdef IOB_ACC_CTRL_SAT_EN
        chk("w_mdata",  32'(m_data_o),  32'h1FFFFF);
`else
        chk("w_mdata",  32'(m_data_o),  32'h000001);
`endif
        chk("w_ovf",    32'(ovf_o),     32'd1);
        step();
        chk("w_ovf_after_hs", 32'(ovf_o), 32'd1);
        start(8'd1);
        chk("w_ovf_before_load", 32'(ovf_o), 32'd1);
        feed(21'd3);
        chk("w_next_ovf",   32'(ovf_o),    32'd0);
        chk("w_next_mdata", 32'(m_data_o), 32'd3);
        step();

        // A start pulse during ACC is ignored: 10 + 20 + 30 = 60
        start(8'd3);
        feed(21'd10);
        feed(21'd20);
        start_i = 1'b1;
        len_i   = 8'd9;
        step();
        start_i = 1'b0;
        len_i   = '0;
        chk("ign_busy",   32'(busy_o),    32'd1);
        chk("ign_mvalid", 32'(m_valid_o), 32'd0);
        feed(21'd30);
        chk("ign_mvalid_end", 32'(m_valid_o), 32'd1);
        chk("ign_mdata",      32'(m_data_o),  32'd60);
        step();

        // With the clock enable low, no state changes: 4 + 5 + 6 = 15
        start(8'd3);
        feed(21'd4);
        cke_i     = 1'b0;
        s_valid_i = 1'b1;
        s_data_i  = 21'd100;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("cke_sready", 32'(s_ready_o), 32'd1);
            chk("cke_mdata",  32'(m_data_o),  32'd4);
        end
        s_valid_i = 1'b0;
        cke_i     = 1'b1;
        feed(21'd5);
        chk("cke_mid_mvalid", 32'(m_valid_o), 32'd0);
        feed(21'd6);
        chk("cke_mvalid", 32'(m_valid_o), 32'd1);
        chk("cke_mdata_end", 32'(m_data_o), 32'd15);
        step();

        // Asynchronous reset in the middle of a frame
        start(8'd5);
        feed(21'd1);
        feed(21'd2);
        chk("ar_pre_mdata", 32'(m_data_o), 32'd3);
        #2 arst_n_i = 1'b0;
        #1;
        chk("ar_busy",   32'(busy_o),    32'd0);
        chk("ar_sready", 32'(s_ready_o), 32'd0);
        chk("ar_mvalid", 32'(m_valid_o), 32'd0);
        chk("ar_mdata",  32'(m_data_o),  32'd0);
        chk("ar_ovf",    32'(ovf_o),     32'd0);
        step();
        arst_n_i = 1'b1;
        step();
        start(8'd2);
        feed(21'd6);
        feed(21'd6);
        chk("ar_new_mvalid", 32'(m_valid_o), 32'd1);
        chk("ar_new_mdata",  32'(m_data_o),  32'd12);
        step();
        chk("ar_new_idle", 32'(busy_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
